// File: rtl/argmax_scan_pkg.sv
// Shared constants for the argmax scan engine: FSM encodings, tie policies and latency bound.
package argmax_pkg;

  localparam int RD_LAT_MAX = 4;

  localparam int TIE_FIRST_WINS = 0;
  localparam int TIE_LAST_WINS  = 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

endpackage

// File: rtl/argmax_scan_rd_lat_pipe.sv
// Tag pipeline that travels alongside each buffer read so returning data can be matched to its
// address. Stage 0 captures the registered read strobe; the last stage lines up with rd_data.
module rd_lat_pipe
  import argmax_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0]             vld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_d;

  // shift every stage down by one, new tag enters at stage 0
  always_comb begin
    vld_d     = vld_q;
    addr_d    = addr_q;
    vld_d[0]  = vld_i;
    addr_d[0] = addr_i;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  // tag storage; cleared on reset so reads in flight at reset are never compared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign addr_o = addr_q[DEPTH-1];

endmodule

// File: rtl/argmax_scan.sv
// Sequential argmax over a synchronous-read buffer: issues one read per cycle, compares the
// returned words as they arrive and reports the index/value of the maximum with a done pulse.
module argmax_scan
  import argmax_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int SIGNED   = 1,
  parameter int TIE_LAST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] size_i,
  output logic              busy_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              done_o,
  output logic [ADDR_W-1:0] max_index_o,
  output logic [DATA_W-1:0] max_value_o,
  output logic              empty_err_o
);

  // out-of-range latencies saturate to the supported window
  localparam int LAT_EFF = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   size_q, size_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                empty_err_q, empty_err_d;
  logic                first_q, first_d;
  logic [ADDR_W-1:0]   best_idx_q, best_idx_d;
  logic [DATA_W-1:0]   best_val_q, best_val_d;
  logic [ADDR_W-1:0]   max_index_q, max_index_d;
  logic [DATA_W-1:0]   max_value_q, max_value_d;

  logic                tap_vld_s;
  logic [ADDR_W-1:0]   tap_addr_s;
  logic [ADDR_W-1:0]   size_last_s;
  logic                cand_gt_s;
  logic                cand_eq_s;
  logic                take_s;
  logic                last_tap_s;

  rd_lat_pipe #(
    .DEPTH  (LAT_EFF),
    .ADDR_W (ADDR_W)
  ) u_rd_lat_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (rd_en_q),
    .addr_i (rd_addr_q),
    .vld_o  (tap_vld_s),
    .addr_o (tap_addr_s)
  );

  assign size_last_s = size_q - ADDR_W'(1);
  assign last_tap_s  = tap_vld_s && (tap_addr_s == size_last_s);

  // running-best comparator; the first returned element seeds the best with no sentinel
  always_comb begin
    if (SIGNED != 0) begin
      cand_gt_s = ($signed(rd_data_i) > $signed(best_val_q));
    end else begin
      cand_gt_s = (rd_data_i > best_val_q);
    end
    cand_eq_s = (rd_data_i == best_val_q);
    take_s    = tap_vld_s &&
                (first_q || cand_gt_s || ((TIE_LAST == TIE_LAST_WINS) && cand_eq_s));
    if (take_s) begin
      best_idx_d = tap_addr_s;
      best_val_d = rd_data_i;
    end else begin
      best_idx_d = best_idx_q;
      best_val_d = best_val_q;
    end
  end

  // scan control: read issue, drain of outstanding reads and result publication
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    empty_err_d = empty_err_q;
    max_index_d = max_index_q;
    max_value_d = max_value_q;
    if (tap_vld_s) begin
      first_d = 1'b0;
    end else begin
      first_d = first_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          size_d      = size_i;
          busy_d      = 1'b1;
          empty_err_d = (size_i == ADDR_W'(0));
          if (size_i == ADDR_W'(0)) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_ISSUE;
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_W'(0);
            first_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (rd_addr_q == size_last_s) begin
          rd_en_d = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (last_tap_s) begin
          state_d     = ST_FIN;
          done_d      = 1'b1;
          max_index_d = best_idx_d;
          max_value_d = best_val_d;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        rd_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      size_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      empty_err_q <= 1'b0;
      first_q     <= 1'b0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      max_index_q <= '0;
      max_value_q <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      empty_err_q <= empty_err_d;
      first_q     <= first_d;
      best_idx_q  <= best_idx_d;
      best_val_q  <= best_val_d;
      max_index_q <= max_index_d;
      max_value_q <= max_value_d;
    end
  end

  assign busy_o      = busy_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign done_o      = done_q;
  assign max_index_o = max_index_q;
  assign max_value_o = max_value_q;
  assign empty_err_o = empty_err_q;

endmodule

// File: tb/tb_argmax_scan.sv
// Directed bench: four argmax_scan variants (signed/first, signed/last, unsigned, latency 3)
// share start/size and a common element memory, each with its own read-latency data pipe.
module tb_argmax_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] size_i = 16'd0;

  wire  [3:0]  busy_v, rd_en_v, done_v, empty_v;
  wire  [15:0] addr_v [4];
  wire  [15:0] idx_v  [4];
  wire  [31:0] val_v  [4];

  logic [31:0] mem [16];
  int          cyc = 0;
  int          c0 = 0;
  int          rd_cnt [4];
  int          done_cnt [4];
  int          done_cyc [4];
  int          checks = 0;
  int          errors = 0;

  logic [15:0] exp_idx [4];
  logic [31:0] exp_val [4];
  int          exp_lat [4];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // per-variant observation counters, sampled on the falling edge
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rd_en_v[g]) rd_cnt[g] <= rd_cnt[g] + 1;
      if (done_v[g]) begin
        done_cnt[g] <= done_cnt[g] + 1;
        done_cyc[g] <= cyc;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT = (g == 3) ? 3 : 1;
    localparam int SG  = (g == 2) ? 0 : 1;
    localparam int TL  = (g == 1) ? 1 : 0;
    logic [31:0] pipe [LAT];
    logic [31:0] rdata;

    always @(posedge clk) begin
      pipe[0] <= rd_en_v[g] ? mem[addr_v[g][3:0]] : 32'h0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rdata = pipe[LAT-1];

    argmax_scan #(
      .DATA_W(32), .ADDR_W(16), .RD_LAT(LAT), .SIGNED(SG), .TIE_LAST(TL)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .size_i      (size_i),
      .busy_o      (busy_v[g]),
      .rd_en_o     (rd_en_v[g]),
      .rd_addr_o   (addr_v[g]),
      .rd_data_i   (rdata),
      .done_o      (done_v[g]),
      .max_index_o (idx_v[g]),
      .max_value_o (val_v[g]),
      .empty_err_o (empty_v[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pulse start for one edge; afterwards the bench sits in cycle 1 of the scan
  task automatic kick(input logic [15:0] n);
    size_i  = n;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    c0      = cyc - 1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy_v == 4'b0000) break;
      tick();
    end
  endtask

  task automatic check_results(input string name, input int dn_base [4]);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (idx_v[g] !== exp_idx[g]) begin
        errors++;
        $display("FAIL %s idx dut%0d got %0d want %0d", name, g, idx_v[g], exp_idx[g]);
      end
      checks++;
      if (val_v[g] !== exp_val[g]) begin
        errors++;
        $display("FAIL %s val dut%0d got %h want %h", name, g, val_v[g], exp_val[g]);
      end
      checks++;
      if (done_cnt[g] - dn_base[g] !== 1) begin
        errors++;
        $display("FAIL %s done_count dut%0d got %0d want 1", name, g, done_cnt[g] - dn_base[g]);
      end
      checks++;
      if (done_cyc[g] - c0 !== exp_lat[g]) begin
        errors++;
        $display("FAIL %s done_cycle dut%0d got %0d want %0d", name, g, done_cyc[g] - c0, exp_lat[g]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({busy_v[g], rd_en_v[g], done_v[g], empty_v[g]} !== 4'b0000 || addr_v[g] !== 16'd0 ||
          idx_v[g] !== 16'd0 || val_v[g] !== 32'd0) begin
        errors++;
        $display("FAIL reset dut%0d got b%0b r%0b d%0b e%0b a%0d i%0d v%h want all zero", g,
                 busy_v[g], rd_en_v[g], done_v[g], empty_v[g], addr_v[g], idx_v[g], val_v[g]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_signed_tie();
    int dn [4];
    int rb [4];
    logic [31:0] v [10];
    v = '{32'd3, -32'sd7, 32'd12, 32'd0, 32'd12, 32'd5, -32'sd1, 32'd9, 32'd2, 32'd4};
    for (int i = 0; i < 10; i++) mem[i] = v[i];
    dn = done_cnt;
    rb = rd_cnt;
    kick(16'd10);
    wait_idle(40);
    exp_idx = '{16'd2, 16'd4, 16'd6, 16'd2};
    exp_val = '{32'd12, 32'd12, 32'hFFFF_FFFF, 32'd12};
    exp_lat = '{12, 12, 12, 14};
    check_results("signed_tie", dn);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (rd_cnt[g] - rb[g] !== 10 || empty_v[g] !== 1'b0) begin
        errors++;
        $display("FAIL signed_tie reads dut%0d got %0d empty %0b want 10 empty 0", g,
                 rd_cnt[g] - rb[g], empty_v[g]);
      end
    end
  endtask

  task automatic test_all_negative();
    int dn [4];
    mem[0] = -32'sd5;
    mem[1] = -32'sd2;
    mem[2] = -32'sd9;
    dn = done_cnt;
    kick(16'd3);
    wait_idle(40);
    exp_idx = '{16'd1, 16'd1, 16'd1, 16'd1};
    exp_val = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    exp_lat = '{5, 5, 5, 7};
    check_results("all_negative", dn);
  endtask

  task automatic test_sign_mode();
    int dn [4];
    mem[0] = 32'h7FFF_FFFF;
    mem[1] = 32'h8000_0000;
    dn = done_cnt;
    kick(16'd2);
    wait_idle(40);
    exp_idx = '{16'd0, 16'd0, 16'd1, 16'd0};
    exp_val = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    exp_lat = '{4, 4, 4, 6};
    check_results("sign_mode", dn);
  endtask

  task automatic test_empty();
    int dn [4];
    int rb [4];
    dn = done_cnt;
    rb = rd_cnt;
    kick(16'd0);
    wait_idle(20);
    tick();
    exp_lat = '{1, 1, 1, 1};
    check_results("empty", dn);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (empty_v[g] !== 1'b1 || rd_cnt[g] - rb[g] !== 0) begin
        errors++;
        $display("FAIL empty flag dut%0d got empty %0b reads %0d want empty 1 reads 0", g,
                 empty_v[g], rd_cnt[g] - rb[g]);
      end
    end
  endtask

  task automatic test_latency();
    int dn [4];
    mem[0] = 32'h8000_0000;
    dn = done_cnt;
    kick(16'd1);
    checks++;
    if (empty_v !== 4'b0000) begin
      errors++;
      $display("FAIL latency empty_clear got %b want 0000", empty_v);
    end
    wait_idle(40);
    exp_idx = '{16'd0, 16'd0, 16'd0, 16'd0};
    exp_val = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    exp_lat = '{3, 3, 3, 5};
    check_results("latency", dn);
  endtask

  task automatic test_start_ignored();
    int dn [4];
    int rb [4];
    for (int i = 0; i < 7; i++) mem[i] = 32'(i + 1);
    mem[7] = 32'd100;
    dn = done_cnt;
    rb = rd_cnt;
    kick(16'd8);
    size_i = 16'd2;
    for (int k = 1; k < 40; k++) begin
      start_i = (k == 3) ? 1'b1 : 1'b0;
      tick();
      start_i = 1'b0;
      if (busy_v == 4'b0000) break;
    end
    exp_idx = '{16'd7, 16'd7, 16'd7, 16'd7};
    exp_val = '{32'd100, 32'd100, 32'd100, 32'd100};
    exp_lat = '{10, 10, 10, 12};
    check_results("start_ignored", dn);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (rd_cnt[g] - rb[g] !== 8) begin
        errors++;
        $display("FAIL start_ignored reads dut%0d got %0d want 8", g, rd_cnt[g] - rb[g]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dn [4];
    int k;
    mem[0] = 32'd1;
    mem[1] = 32'd9;
    dn = done_cnt;
    kick(16'd2);
    k = 1;
    while (done_v[0] !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (k !== 4) begin
      errors++;
      $display("FAIL back_to_back first_done got cycle %0d want 4", k);
    end
    mem[0] = 32'd20;
    mem[1] = 32'd5;
    tick();
    kick(16'd2);
    checks++;
    if (busy_v !== 4'b1111) begin
      errors++;
      $display("FAIL back_to_back accept got busy %b want 1111", busy_v);
    end
    wait_idle(40);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (done_cnt[g] - dn[g] !== 2 || done_cyc[g] - c0 !== 4 || idx_v[g] !== 16'd0 ||
          val_v[g] !== 32'd20) begin
        errors++;
        $display("FAIL back_to_back second dut%0d got dones %0d cycle %0d idx %0d val %0d want 2 4 0 20",
                 g, done_cnt[g] - dn[g], done_cyc[g] - c0, idx_v[g], val_v[g]);
      end
    end
    checks++;
    if (done_cnt[3] - dn[3] !== 1 || idx_v[3] !== 16'd1 || val_v[3] !== 32'd9) begin
      errors++;
      $display("FAIL back_to_back busy_ignore dut3 got dones %0d idx %0d val %0d want 1 1 9",
               done_cnt[3] - dn[3], idx_v[3], val_v[3]);
    end
  endtask

  task automatic test_reset_mid();
    int dn [4];
    for (int i = 0; i < 8; i++) mem[i] = 32'd1000 + 32'(i);
    dn = done_cnt;
    kick(16'd8);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({busy_v[g], rd_en_v[g], done_v[g], empty_v[g]} !== 4'b0000 || addr_v[g] !== 16'd0 ||
          idx_v[g] !== 16'd0 || val_v[g] !== 32'd0) begin
        errors++;
        $display("FAIL reset_mid dut%0d got b%0b r%0b d%0b a%0d i%0d v%h want all zero", g,
                 busy_v[g], rd_en_v[g], done_v[g], addr_v[g], idx_v[g], val_v[g]);
      end
    end
    tick();
    rst_n = 1'b1;
    mem[0] = 32'd10;
    mem[1] = 32'd30;
    mem[2] = 32'd20;
    kick(16'd3);
    wait_idle(40);
    exp_idx = '{16'd1, 16'd1, 16'd1, 16'd1};
    exp_val = '{32'd30, 32'd30, 32'd30, 32'd30};
    exp_lat = '{5, 5, 5, 7};
    check_results("reset_mid", dn);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    test_reset();
    test_signed_tie();
    test_all_negative();
    test_sign_mode();
    test_empty();
    test_latency();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
